// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants used by the execute-stage units.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } m_func3_e;

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, XLEN cycles per divide.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_d;
  logic [XLEN-1:0] r_r;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;

  // The dividend is shifted out of r_q while quotient bits are shifted in.
  assign w_shift = {r_r, r_q[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_d};
  assign done      = r_busy && (r_cnt == LAST);
  assign quotient  = r_q;
  assign remainder = r_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_r    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_q    <= dividend;
      r_d    <= divisor;
      r_r    <= '0;
    end else if (done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_diff[XLEN]) begin
        r_r <= w_diff[XLEN-1:0];
        r_q <= {r_q[XLEN-2:0], 1'b1};
      end else begin
        r_r <= w_shift[XLEN-1:0];
        r_q <= {r_q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential RV32M multiply/divide unit with valid/ready request and result handshakes.
module mul_div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter bit          SIGN_FIXUP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        r_state, w_next;
  logic [XLEN-1:0]   r_result;
  logic              r_is_rem, r_neg_q, r_neg_r;

  m_func3_e          w_f3;
  logic              w_accept, w_is_m, w_signed_div, w_div_zero, w_ovf, w_slow;
  logic              w_sa, w_sb;
  logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast;
  logic              w_div_done;
  logic [XLEN-1:0]   w_quot, w_rem;

  assign w_f3         = m_func3_e'(func3);
  assign w_accept     = in_valid && (r_state == ST_IDLE);
  assign w_is_m       = (opcode == OPCODE_OP) && (func7 == FUNC7_MULDIV);
  assign w_signed_div = SIGN_FIXUP && ((w_f3 == DIV) || (w_f3 == REM));
  assign w_div_zero   = (data2 == '0);
  assign w_ovf        = w_signed_div && (data1 == INT_MIN) && (data2 == '1);
  assign w_slow       = w_is_m && func3[2] && !w_div_zero && !w_ovf;

  // Sign/zero-extend to 2*XLEN so one truncated multiply serves all four variants.
  assign w_sa    = (w_f3 == MULH) || (w_f3 == MULHSU);
  assign w_sb    = (w_f3 == MULH);
  assign w_a_ext = {{XLEN{w_sa & data1[XLEN-1]}}, data1};
  assign w_b_ext = {{XLEN{w_sb & data2[XLEN-1]}}, data2};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_mag_a = (w_signed_div && data1[XLEN-1]) ? -data1 : data1;
  assign w_mag_b = (w_signed_div && data2[XLEN-1]) ? -data2 : data2;

  always_comb begin
    w_fast = '0;
    if (w_is_m) begin
      case (w_f3)
        MUL:                  w_fast = w_prod[XLEN-1:0];
        MULH, MULHSU, MULHU:  w_fast = w_prod[2*XLEN-1:XLEN];
        default: begin
          if (w_div_zero)  w_fast = func3[1] ? data1 : '1;
          else if (w_ovf)  w_fast = func3[1] ? '0 : data1;
        end
      endcase
    end
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_accept && w_slow),
    .dividend  (w_mag_a),
    .divisor   (w_mag_b),
    .done      (w_div_done),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  // ST_MUL is the single-cycle result stage shared by multiplies, special-case
  // divides and non-M encodings, so all of them see the same 1-cycle latency.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_slow ? ST_DIV : ST_MUL;
      end
      ST_MUL:  w_next = ST_DONE;
      ST_DIV:  if (w_div_done) w_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_result <= w_fast;
        r_is_rem <= func3[1];
        r_neg_q  <= w_signed_div && (data1[XLEN-1] ^ data2[XLEN-1]);
        r_neg_r  <= w_signed_div && data1[XLEN-1];
      end else if ((r_state == ST_DIV) && w_div_done) begin
        if (r_is_rem) r_result <= r_neg_r ? -w_rem : w_rem;
        else          r_result <= r_neg_q ? -w_quot : w_quot;
      end
    end
  end

  assign result = r_result;

endmodule
